// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// op and state encodings, iteration count and a magnitude helper.
package ex_muldiv_unit_pkg;

    localparam int MD_WIDTH      = 32;
    localparam int MULDIV_CYCLES = MD_WIDTH;
    localparam int CNT_W         = $clog2(MULDIV_CYCLES);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIXUP,
        S_DONE
    } state_e;

    // Magnitude for signed ops, raw value otherwise.
    // -0x80000000 wraps to itself, which reads correctly as unsigned.
    function automatic logic [MD_WIDTH-1:0] mag(
        input logic [MD_WIDTH-1:0] v,
        input logic                sgn
    );
        return (sgn && v[MD_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle of the mul/div unit: ID/EX operands, MTHI/MTLO
// writes, stall/done/div_zero status and the HI/LO registers.
// master = pipeline, slave = mul/div unit.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    import ex_muldiv_unit_pkg::*;

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
        input  stall, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
        output stall, done, div_zero, hi, lo
    );

endinterface

// File: rtl/ex_muldiv_unit_step.sv
// muldiv_step: one combinational iteration of the mul/div datapath.
// Ports: i_acc (accumulator / remainder:quotient), i_opnd (multiplicand or
// divisor), i_div (1 = divide); o_acc next accumulator, o_q quotient bit.
module muldiv_step
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_q
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    always_comb begin
        // Multiply: acc = {partial, multiplier}; add on LSB, shift right.
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                 + (i_acc[0] ? {1'b0, i_opnd} : '0);
        // Divide: acc = {remainder, dividend/quotient}; shift left 1.
        w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        w_fits   = ~w_diff[WIDTH];
        o_q      = 1'b0;
        o_acc    = '0;
        if (i_div) begin
            o_q   = w_fits;
            o_acc = {(w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                     i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO.
// Ports: clk, reset (sync, active-high), mdu (slave side of the bundle).
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    ex_muldiv_unit_if.slave    mdu
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_W-1:0]     r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_step;
    logic                 w_q;
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_done;
    logic                 r_div_zero;
    logic                 w_signed;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_dz;

    assign w_signed = (mdu.op == OP_MULT) || (mdu.op == OP_DIV);
    assign w_mag_a  = mag(mdu.src_a, w_signed);
    assign w_mag_b  = mag(mdu.src_b, w_signed);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc  (r_acc),
        .i_opnd (r_opb),
        .i_div  (r_is_div),
        .o_acc  (w_acc_step),
        .o_q    (w_q)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        mdu.stall   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (mdu.start) begin
                    w_state_nxt = S_BUSY;
                    mdu.stall   = 1'b1;
                end
            end
            S_BUSY: begin
                mdu.stall = 1'b1;
                if (r_count == CNT_W'(MULDIV_CYCLES - 1))
                    w_state_nxt = S_FIXUP;
            end
            S_FIXUP: begin
                mdu.stall   = 1'b1;
                w_state_nxt = S_DONE;
            end
            // DONE still holds the same instruction, so start is ignored.
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sign fixup on the unsigned magnitude result.
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                            : r_acc[2*WIDTH-1:WIDTH];
    assign w_dz   = r_is_div && (r_opb == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (mdu.start) begin
                        r_opa    <= w_mag_a;
                        r_opb    <= w_mag_b;
                        r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                        r_is_div <= mdu.op[1];
                        r_neg_q  <= w_signed
                                  && (mdu.src_a[WIDTH-1] ^ mdu.src_b[WIDTH-1]);
                        r_neg_r  <= w_signed && mdu.src_a[WIDTH-1];
                        r_count  <= '0;
                    end else begin
                        if (mdu.hi_we) r_hi <= mdu.wdata;
                        if (mdu.lo_we) r_lo <= mdu.wdata;
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_acc_step | {{(2*WIDTH-1){1'b0}}, w_q};
                    r_count <= r_count + 1'b1;
                end
                S_FIXUP: begin
                    r_done     <= 1'b1;
                    r_div_zero <= w_dz;
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (w_dz) begin
                        // Rebuild the dividend exactly as presented.
                        r_hi <= r_neg_r ? -r_opa : r_opa;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mdu.done     = r_done;
    assign mdu.div_zero = r_div_zero;
    assign mdu.hi       = r_hi;
    assign mdu.lo       = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed mul/div vectors,
// MTHI/MTLO, reset abort and start-hold cases.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.WIDTH(32)) m ();

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (m)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_done = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic expect_res(input string nm, input logic [31:0] hi,
                              input logic [31:0] lo, input logic dz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dz = dz;
        e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (!reset && m.done) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                n_tot++;
                $display("FAIL spurious_done: got done=1 want none");
            end else begin
                e = q.pop_front();
                chk({e.nm, "_hi"}, m.hi, e.hi);
                chk({e.nm, "_lo"}, m.lo, e.lo);
                chk({e.nm, "_dz"}, {31'b0, m.div_zero}, {31'b0, e.dz});
            end
        end
    end

    task automatic wait_done(input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m.done) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, "_done_seen"}, {31'b0, got}, 32'd1);
    endtask

    // Issue one op, count stall cycles up to and including done.
    task automatic issue(input string nm, input op_e op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz);
        int   n;
        logic got;
        expect_res(nm, ehi, elo, edz);
        @(posedge clk); #1;
        m.start = 1'b1;
        m.op    = op;
        m.src_a = a;
        m.src_b = b;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m.stall) n++;
            if (m.done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            m.start = 1'b0;
        end
        chk({nm, "_stall_cycles"}, n, 34);
        chk({nm, "_done_seen"}, {31'b0, got}, 32'd1);
    endtask

    initial begin
        int d0;
        reset   = 1'b1;
        m.start = 1'b0;
        m.op    = OP_MULT;
        m.src_a = '0;
        m.src_b = '0;
        m.hi_we = 1'b0;
        m.lo_we = 1'b0;
        m.wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", m.hi, 32'h0);
        chk("rst_lo", m.lo, 32'h0);
        chk("rst_stall", {31'b0, m.stall}, 32'h0);
        chk("rst_done", {31'b0, m.done}, 32'h0);

        // MTLO in IDLE
        @(posedge clk); #1;
        m.lo_we = 1'b1;
        m.wdata = 32'h1234;
        @(posedge clk); #1;
        m.lo_we = 1'b0;
        @(negedge clk);
        chk("mtlo_idle", m.lo, 32'h1234);

        issue("mult", OP_MULT, 32'hFFFFFFFF, 32'h2,
              32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        issue("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2,
              32'h00000001, 32'hFFFFFFFE, 1'b0);
        issue("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue("divu", OP_DIVU, 32'd100, 32'd7,
              32'd2, 32'd14, 1'b0);
        issue("divu_zero", OP_DIVU, 32'd100, 32'd0,
              32'd100, 32'hFFFFFFFF, 1'b1);
        issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
              32'h0, 32'h80000000, 1'b0);

        // MTLO while busy is dropped
        expect_res("lo_we_busy", 32'h0, 32'd15, 1'b0);
        @(posedge clk); #1;
        m.start = 1'b1;
        m.op    = OP_MULTU;
        m.src_a = 32'd3;
        m.src_b = 32'd5;
        @(posedge clk); #1;
        m.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m.lo_we = 1'b1;
        m.wdata = 32'h0BAD;
        @(posedge clk); #1;
        m.lo_we = 1'b0;
        @(negedge clk);
        chk("lo_we_busy_hold", m.lo, 32'h80000000);
        wait_done("lo_we_busy");

        // start wins over MTHI in the same cycle
        @(posedge clk); #1;
        m.hi_we = 1'b1;
        m.wdata = 32'h55;
        @(posedge clk); #1;
        m.hi_we = 1'b0;
        @(negedge clk);
        chk("mthi_idle", m.hi, 32'h55);
        expect_res("start_hi_we", 32'h0, 32'd6, 1'b0);
        @(posedge clk); #1;
        m.start = 1'b1;
        m.op    = OP_MULTU;
        m.src_a = 32'd2;
        m.src_b = 32'd3;
        m.hi_we = 1'b1;
        m.wdata = 32'hAAAA;
        @(posedge clk); #1;
        m.start = 1'b0;
        m.hi_we = 1'b0;
        @(negedge clk);
        chk("start_hi_we_drop", m.hi, 32'h55);
        wait_done("start_hi_we");

        // Reset in the 10th BUSY cycle aborts silently
        @(posedge clk); #1;
        d0 = n_done;
        m.start = 1'b1;
        m.op    = OP_MULTU;
        m.src_a = 32'd7;
        m.src_b = 32'd9;
        @(posedge clk); #1;
        m.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_stall", {31'b0, m.stall}, 32'h0);
        chk("abort_hi", m.hi, 32'h0);
        chk("abort_lo", m.lo, 32'h0);
        repeat (45) @(negedge clk);
        chk("abort_no_done", n_done, d0);

        // start held through DONE: one op, then a second from IDLE
        d0 = n_done;
        expect_res("hold_op1", 32'h0, 32'd42, 1'b0);
        expect_res("hold_op2", 32'h0, 32'd18, 1'b0);
        @(posedge clk); #1;
        m.start = 1'b1;
        m.op    = OP_MULTU;
        m.src_a = 32'd6;
        m.src_b = 32'd7;
        wait_done("hold_op1");
        chk("hold_done_stall", {31'b0, m.stall}, 32'h0);
        m.src_a = 32'd2;
        m.src_b = 32'd9;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_relaunch_stall", {31'b0, m.stall}, 32'h1);
        @(posedge clk); #1;
        m.start = 1'b0;
        wait_done("hold_op2");
        repeat (40) @(negedge clk);
        chk("hold_done_count", n_done, d0 + 2);
        chk("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide engine in the EX stage.
- Consumes the operand and control fields that the ID/EX pipeline register delivers: operand A, operand B and the decoded mul/div op.
- Drives a stall back to the IF/ID and ID/EX registers while the operation runs, and owns the architectural HI/LO registers used by MFHI/MFLO/MTHI/MTLO.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported in this design; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  a mul/div instruction is present in EX (from ID/EX).
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  input  WIDTH  rs value (ID/EX operand 1).
- src_b  input  WIDTH  rt value (ID/EX operand 2).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- stall  output  1  freeze IF/ID and ID/EX; combinational.
- done  output  1  one-cycle completion pulse; registered.
- div_zero  output  1  asserted with done when a DIV/DIVU had src_b==0; registered.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous): state=IDLE, count=0, hi=0, lo=0, done=0, div_zero=0, internal operand registers=0. Reset overrides every other input, including mid-operation. An aborted operation produces no done pulse and leaves hi/lo=0.
- States: IDLE, BUSY, FIXUP, DONE.
- IDLE with start=1:
  - latch |src_a| and |src_b| (magnitudes for signed ops, raw values for unsigned ops), the op, and the result-sign flags;
  - count=0, then go to BUSY.
- IDLE with start=0: apply MTHI/MTLO. If hi_we, hi<=wdata; if lo_we, lo<=wdata.
- start and a write in the same cycle: start wins and the write is dropped.
- BUSY: one iteration per cycle; count increments.
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - After the iteration with count==WIDTH-1, go to FIXUP.
- FIXUP: apply the sign correction and write hi/lo, then go to DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend (truncating division).
  - Multiply: hi=product[63:32], lo=product[31:0]. Divide: lo=quotient, hi=remainder.
- DONE: done=1 for exactly this cycle, and div_zero is valid. stall=0, and start is ignored here because it is still the same instruction. Go to IDLE.
- stall = (state==IDLE && start) || state==BUSY || state==FIXUP.
  - An instruction issued at cycle k stalls cycles k..k+33 (34 cycles).
  - done is high in cycle k+34 with hi/lo already valid; the pipeline advances at the end of that cycle.
- start, op, src_a, src_b are sampled only in IDLE. Changes to them while BUSY or FIXUP are ignored.
- MTHI/MTLO writes in BUSY, FIXUP or DONE are dropped; the pipeline is stalled in BUSY and FIXUP anyway.
- Divide by zero (src_b==0, DIV or DIVU):
  - lo=0xFFFFFFFF, hi=src_a as originally presented, regardless of signedness;
  - div_zero=1 in the DONE cycle;
  - latency unchanged.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, div_zero=0.
- Arithmetic width: all magnitude math is unsigned WIDTH / 2*WIDTH with no truncation before FIXUP. The negation of 0x80000000 wraps to itself.

Decomposition:
- Shared package contents: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encodings, MULDIV_CYCLES=WIDTH.
- One sub-module, muldiv_step: combinational single-iteration datapath. It takes the accumulator/remainder, multiplicand/divisor and a mode bit, and returns the next accumulator and quotient bit.
- The top level keeps the FSM, counter, sign fixup and HI/LO registers.

Test Plan:
- Sign handling: MULT src_a=0xFFFFFFFF, src_b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE. For both: stall high for exactly 34 cycles, then done for 1 cycle.
- Truncating divide: DIV src_a=0xFFFFFFF9 (-7), src_b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- Divide by zero and overflow:
  - DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, div_zero=1 coincident with done.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Reset mid-operation: assert reset in the 10th BUSY cycle -> next cycle stall=0, hi=lo=0, and no done pulse ever follows.
- No re-issue: hold start=1 continuously through DONE -> exactly one operation and one done. A new start in the cycle after DONE launches a second op.
- MTHI/MTLO: lo_we with wdata=0x1234 in IDLE -> lo=0x1234. lo_we while BUSY -> ignored, and lo equals the op result. start together with hi_we -> hi_we dropped.
